axis_join_collector: RTL and testbench

- Upstream-facing return path of the multi-chip datapath. Merges S_COUNT per-chip AXI-Stream result channels into one stream toward the host DMA.
- Beats are taken from active inputs by round-robin; each input's end marker (beat with tlast=1) is absorbed.
- Once every enabled input has delivered its end marker, exactly one all-ones end word with tlast=1 goes out, closing the frame.
- Output is registered through a skid buffer so no ready path passes through the block combinationally.

---
 rtl/paicore_axis_pkg.sv | 25 ++
 rtl/axis_join_collector_if.sv | 21 ++
 rtl/axis_skid_buffer.sv | 77 +++++++
 rtl/axis_join_collector.sv | 156 +++++++++++++++
 tb/tb_axis_join_collector.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/paicore_axis_pkg.sv
// +----------------------------------------------------------------------------
// | paicore_axis_pkg
// | Constants and types shared by the fork and join ends of the AXIS datapath.
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package paicore_axis_pkg;

    // Wide enough for any datapath width; users slice the low DATA_WIDTH bits.
    localparam int                         EOF_MAX_WIDTH = 1024;
    localparam logic [EOF_MAX_WIDTH-1:0]   EOF_WORD      = '1;

    typedef enum logic [0:0] {
        ST_MERGE    = 1'b0,
        ST_EMIT_END = 1'b1
    } join_state_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_join_collector_if.sv
// +----------------------------------------------------------------------------
// | axis_join_collector_if
// | Multi-lane AXI-Stream bundle; LANES=1 gives a plain single stream.
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

interface axis_join_collector_if #(
    parameter int LANES      = 1,
    parameter int DATA_WIDTH = 64
);
    logic [LANES*DATA_WIDTH-1:0] tdata;
    logic [LANES-1:0]            tlast;
    logic [LANES-1:0]            tvalid;
    logic [LANES-1:0]            tready;

    modport master (output tdata, output tlast, output tvalid, input  tready);
    modport slave  (input  tdata, input  tlast, input  tvalid, output tready);
endinterface

`default_nettype wire

// File: rtl/axis_skid_buffer.sv
// +----------------------------------------------------------------------------
// | axis_skid_buffer
// | Two-entry in-order buffer with a registered input ready.
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module axis_skid_buffer #(
    parameter int WIDTH = 65
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] s_data,
    input  wire logic             s_valid,
    output      logic             s_ready,
    output      logic [WIDTH-1:0] m_data,
    output      logic             m_valid,
    input  wire logic             m_ready
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_count;
    logic             r_ready;
    logic [1:0]       w_count_next;
    logic             w_push;
    logic             w_pop;

    assign w_push = s_valid & r_ready;
    assign w_pop  = (r_count != 2'd0) & m_ready;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    // Ready tracks the occupancy that results from this edge, so a push can
    // never land while both entries are held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
            r_ready <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_ready <= (w_count_next != 2'd2);
            case ({w_push, w_pop})
                2'b01: r_head <= r_tail;
                2'b10: begin
                    if (r_count == 2'd0) r_head <= s_data;
                    else                 r_tail <= s_data;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= s_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= s_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_ready = r_ready;
    assign m_data  = r_head;
    assign m_valid = (r_count != 2'd0);

endmodule

`default_nettype wire

// File: rtl/axis_join_collector.sv
// +----------------------------------------------------------------------------
// | axis_join_collector
// | Round-robin merge of per-chip result streams, closed by one all-ones end word.
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module axis_join_collector
    import paicore_axis_pkg::*;
#(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic [S_COUNT-1:0]   oen,
    axis_join_collector_if.slave      s_axis,
    axis_join_collector_if.master     m_axis,
    output      logic                 busy,
    output      logic                 frame_done,
    output      logic [CNT_WIDTH-1:0] beat_count
);

    localparam int PTR_W = ptr_width(S_COUNT);

    join_state_t           r_state;
    join_state_t           w_state_next;
    logic [S_COUNT-1:0]    r_done;
    logic [PTR_W-1:0]      r_ptr;
    logic [CNT_WIDTH-1:0]  r_beat_count;

    logic [S_COUNT-1:0]    w_eligible;
    logic [S_COUNT-1:0]    w_grant;
    logic [PTR_W-1:0]      w_grant_idx;
    logic [PTR_W-1:0]      w_ptr_next;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_sel_last;
    logic                  w_skid_ready;
    logic                  w_accept;
    logic                  w_emit;
    logic                  w_emit_fire;
    logic                  w_push_valid;
    logic [DATA_WIDTH:0]   w_push_data;
    logic [DATA_WIDTH:0]   w_out_data;
    logic                  w_out_valid;
    logic                  w_out_ready;

    assign w_emit     = (r_state == ST_EMIT_END);
    assign w_eligible = s_axis.tvalid & oen & ~r_done & {S_COUNT{r_state == ST_MERGE}};

    generate
        if (S_COUNT == 1) begin : g_arb_single
            assign w_grant     = w_eligible;
            assign w_grant_idx = '0;
        end else begin : g_arb_rr
            // Descending offset scan: the last hit is the closest lane at or after r_ptr.
            always_comb begin
                int w_pos;
                w_grant     = '0;
                w_grant_idx = '0;
                for (int k = S_COUNT - 1; k >= 0; k--) begin
                    w_pos = int'(r_ptr) + k;
                    if (w_pos >= S_COUNT) w_pos = w_pos - S_COUNT;
                    for (int i = 0; i < S_COUNT; i++) begin
                        if (w_eligible[i] && (w_pos == i)) begin
                            w_grant     = '0;
                            w_grant[i]  = 1'b1;
                            w_grant_idx = PTR_W'(i);
                        end
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        w_sel_data = '0;
        w_sel_last = 1'b0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (w_grant[i]) begin
                w_sel_data = s_axis.tdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_last = s_axis.tlast[i];
            end
        end
    end

    assign s_axis.tready = w_grant & {S_COUNT{w_skid_ready}};
    assign w_accept      = (|w_grant) & w_skid_ready;
    assign w_emit_fire   = w_emit & w_skid_ready;
    assign w_ptr_next    = (w_grant_idx == PTR_W'(S_COUNT - 1)) ? '0 : w_grant_idx + PTR_W'(1);

    // End markers are absorbed: only data beats and the end word enter the buffer.
    assign w_push_valid = (w_accept & ~w_sel_last) | w_emit;
    assign w_push_data  = w_emit ? {1'b1, EOF_WORD[DATA_WIDTH-1:0]} : {1'b0, w_sel_data};

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_MERGE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_MERGE: begin
                if ((oen != '0) && ((r_done & oen) == oen)) w_state_next = ST_EMIT_END;
            end
            ST_EMIT_END: begin
                if (w_skid_ready) w_state_next = ST_MERGE;
            end
            default: w_state_next = ST_MERGE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done       <= '0;
            r_ptr        <= '0;
            r_beat_count <= '0;
        end else begin
            if (w_emit_fire) begin
                r_done       <= '0;
                r_beat_count <= '0;
            end else if (w_accept) begin
                if (w_sel_last) r_done       <= r_done | w_grant;
                else            r_beat_count <= r_beat_count + CNT_WIDTH'(1);
            end
            if (w_accept) r_ptr <= w_ptr_next;
        end
    end

    axis_skid_buffer #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .s_data  (w_push_data),
        .s_valid (w_push_valid),
        .s_ready (w_skid_ready),
        .m_data  (w_out_data),
        .m_valid (w_out_valid),
        .m_ready (w_out_ready)
    );

    assign w_out_ready   = m_axis.tready[0];
    assign m_axis.tdata  = w_out_data[DATA_WIDTH-1:0];
    assign m_axis.tlast  = w_out_data[DATA_WIDTH];
    assign m_axis.tvalid = w_out_valid;

    assign busy       = (|r_done) | w_emit;
    assign frame_done = w_emit_fire;
    assign beat_count = r_beat_count;

endmodule

`default_nettype wire

// File: tb/tb_axis_join_collector.sv
// +----------------------------------------------------------------------------
// | tb_axis_join_collector
// | Directed bench for the round-robin join collector.
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_axis_join_collector;

    localparam int S  = 4;
    localparam int DW = 64;
    localparam int CW = 32;

    localparam logic [64:0] MARK = {1'b1, 64'h0000_0000_0000_DEAD};
    localparam logic [64:0] EOFB = {1'b1, {64{1'b1}}};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [S-1:0]  oen;
    logic          busy;
    logic          frame_done;
    logic [CW-1:0] beat_count;

    axis_join_collector_if #(.LANES(S), .DATA_WIDTH(DW)) s_if ();
    axis_join_collector_if #(.LANES(1), .DATA_WIDTH(DW)) m_if ();

    axis_join_collector #(
        .S_COUNT    (S),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .oen        (oen),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .busy       (busy),
        .frame_done (frame_done),
        .beat_count (beat_count)
    );

    always #5 clk = ~clk;

    logic [64:0] src_q [S][$];
    logic [64:0] out_q [$];
    logic [64:0] exp_q [$];
    logic [S-1:0] hold;
    logic [S-1:0] seen_ready;
    logic [64:0]  prev_out;
    bit           prev_stall;
    bit           rdy_toggle;
    int total = 0;
    int bad   = 0;
    int fd_cnt, fd_beat, push_cnt, pop_cnt, max_occ;

    function automatic logic [64:0] mk(input logic [63:0] d);
        return {1'b0, d};
    endfunction

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < S; i++) begin
            if (src_q[i].size() > 0) begin
                s_if.tvalid[i]            = 1'b1;
                s_if.tlast[i]             = src_q[i][0][64];
                s_if.tdata[i*DW +: DW]    = src_q[i][0][63:0];
            end else begin
                s_if.tvalid[i]            = hold[i];
                s_if.tlast[i]             = 1'b0;
                s_if.tdata[i*DW +: DW]    = hold[i] ? 64'hBAD : 64'h0;
            end
        end
    endtask

    // Observe at the falling edge, update stimulus just after the rising edge.
    task automatic tick();
        logic [S-1:0] acc;
        @(negedge clk);
        check("tready_without_tvalid", 65'(s_if.tready & ~s_if.tvalid), 65'd0);
        if (prev_stall) begin
            check("stall_tvalid", 65'(m_if.tvalid), 65'd1);
            check("stall_data", {m_if.tlast, m_if.tdata}, prev_out);
        end
        prev_stall  = m_if.tvalid[0] & ~m_if.tready[0];
        prev_out    = {m_if.tlast, m_if.tdata};
        seen_ready |= s_if.tready;
        acc         = s_if.tready & s_if.tvalid;
        for (int i = 0; i < S; i++)
            if (acc[i] && !s_if.tlast[i]) push_cnt++;
        if (frame_done) begin
            fd_cnt++;
            fd_beat = int'(beat_count);
            push_cnt++;
        end
        if (m_if.tvalid[0] && m_if.tready[0]) begin
            out_q.push_back({m_if.tlast, m_if.tdata});
            pop_cnt++;
        end
        if (push_cnt - pop_cnt > max_occ) max_occ = push_cnt - pop_cnt;
        @(posedge clk);
        #1;
        for (int i = 0; i < S; i++)
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (rdy_toggle) m_if.tready = ~m_if.tready;
        drive_inputs();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst        = 1'b0;
        prev_stall = 1'b0;
        push_cnt   = 0;
        pop_cnt    = 0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tvalid"}, 65'(m_if.tvalid), 65'd0);
        check({tag, "_tdata"}, {m_if.tlast, m_if.tdata}, 65'd0);
        check({tag, "_busy"}, 65'(busy), 65'd0);
        check({tag, "_frame_done"}, 65'(frame_done), 65'd0);
        check({tag, "_beat_count"}, 65'(beat_count), 65'd0);
        check({tag, "_s_tready"}, 65'(s_if.tready), 65'd0);
    endtask

    task automatic new_test();
        fd_cnt     = 0;
        fd_beat    = -1;
        max_occ    = 0;
        seen_ready = '0;
        out_q.delete();
        exp_q.delete();
    endtask

    task automatic run_until(input string tag, input int n, input int budget);
        int c = 0;
        while (out_q.size() < n && c < budget) begin
            tick();
            c++;
        end
        check({tag, "_timeout"}, 65'(out_q.size() >= n), 65'd1);
        repeat (4) tick();
    endtask

    task automatic compare_out(input string tag);
        check({tag, "_count"}, 65'(out_q.size()), 65'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), out_q[i], exp_q[i]);
    endtask

    initial begin
        oen         = '0;
        hold        = '0;
        m_if.tready = 1'b1;
        rdy_toggle  = 1'b0;
        drive_inputs();
        apply_reset();
        check_idle("reset");

        // Four lanes, three beats each, interleaved by round robin.
        new_test();
        oen = 4'b1111;
        for (int i = 0; i < S; i++) begin
            for (int j = 0; j < 3; j++) src_q[i].push_back(mk(64'(i * 16 + j)));
            src_q[i].push_back(MARK);
        end
        for (int j = 0; j < 3; j++)
            for (int i = 0; i < S; i++) exp_q.push_back(mk(64'(i * 16 + j)));
        exp_q.push_back(EOFB);
        drive_inputs();
        run_until("rr4", 13, 100);
        compare_out("rr4");
        check("rr4_frame_done_count", 65'(fd_cnt), 65'd1);
        check("rr4_beat_count_at_done", 65'(fd_beat), 65'd12);
        check("rr4_beat_count_cleared", 65'(beat_count), 65'd0);
        check("rr4_busy_after", 65'(busy), 65'd0);

        // Lanes 1 and 3 disabled while holding tvalid.
        new_test();
        oen  = 4'b0101;
        hold = 4'b1010;
        src_q[0] = '{mk(64'h100), MARK};
        src_q[2] = '{mk(64'h200), mk(64'h201), MARK};
        exp_q    = '{mk(64'h100), mk(64'h200), mk(64'h201), EOFB};
        drive_inputs();
        run_until("oen0101", 4, 60);
        compare_out("oen0101");
        check("oen0101_disabled_ready", 65'(seen_ready & 4'b1010), 65'd0);
        check("oen0101_frame_done_count", 65'(fd_cnt), 65'd1);
        hold = '0;

        // Lane 2 marks early; its next beat must wait for the following frame.
        new_test();
        src_q[0] = '{mk(64'h300), mk(64'h301), MARK, MARK};
        src_q[2] = '{MARK, mk(64'hAA), MARK};
        exp_q    = '{mk(64'h300), mk(64'h301), EOFB, mk(64'hAA), EOFB};
        drive_inputs();
        run_until("early", 5, 80);
        compare_out("early");
        check("early_frame_done_count", 65'(fd_cnt), 65'd2);

        // Downstream ready toggling every cycle on a single stream.
        new_test();
        oen = 4'b0001;
        for (int j = 0; j < 16; j++) begin
            src_q[0].push_back(mk(64'(j)));
            exp_q.push_back(mk(64'(j)));
        end
        src_q[0].push_back(MARK);
        exp_q.push_back(EOFB);
        rdy_toggle = 1'b1;
        drive_inputs();
        run_until("bp", 17, 200);
        compare_out("bp");
        check("bp_max_occupancy_le2", 65'(max_occ <= 2), 65'd1);
        check("bp_beat_count_at_done", 65'(fd_beat), 65'd16);
        rdy_toggle  = 1'b0;
        m_if.tready = 1'b1;

        // Buffer full when the frame completes: the end word must wait.
        new_test();
        m_if.tready = 1'b0;
        oen = 4'b0111;
        src_q[0] = '{MARK};
        src_q[1] = '{MARK};
        src_q[2] = '{mk(64'h520), mk(64'h521)};
        drive_inputs();
        repeat (6) tick();
        oen = 4'b0011;
        repeat (10) tick();
        check("hold_busy", 65'(busy), 65'd1);
        check("hold_head", {m_if.tlast, m_if.tdata}, mk(64'h520));
        check("hold_no_frame_done", 65'(fd_cnt), 65'd0);
        check("hold_no_output", 65'(out_q.size()), 65'd0);
        m_if.tready = 1'b1;
        exp_q = '{mk(64'h520), mk(64'h521), EOFB};
        run_until("hold", 3, 30);
        compare_out("hold");
        check("hold_frame_done_count", 65'(fd_cnt), 65'd1);

        // Reset in the middle of a frame with lanes 0 and 1 already done.
        new_test();
        m_if.tready = 1'b0;
        oen = 4'b1111;
        src_q[0] = '{mk(64'h600), MARK};
        src_q[1] = '{MARK};
        drive_inputs();
        repeat (6) tick();
        check("midrst_busy_before", 65'(busy), 65'd1);
        check("midrst_tvalid_before", 65'(m_if.tvalid), 65'd1);
        apply_reset();
        check_idle("midrst");
        new_test();
        m_if.tready = 1'b1;
        src_q[0] = '{mk(64'h620), MARK};
        src_q[1] = '{MARK};
        src_q[2] = '{MARK};
        src_q[3] = '{MARK};
        exp_q    = '{mk(64'h620), EOFB};
        drive_inputs();
        run_until("postrst", 2, 40);
        compare_out("postrst");
        check("postrst_beat_count_at_done", 65'(fd_beat), 65'd1);
        for (int i = 0; i < S; i++)
            check($sformatf("postrst_lane%0d_drained", i), 65'(src_q[i].size()), 65'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
